// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave: four 32-bit R/W registers in 16 word slots; AXIL_REG_SLVERR_EN makes unmapped slots return SLVERR.
// Latency: BVALID two cycles after the later of the AW/W handshakes; RVALID one cycle after the AR handshake.
// Backpressure: one write and one read outstanding; AW/W/AR ready stay low while the matching response is held.
module axi_lite_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   slv_regs
);

    localparam int NUM_REGS = 4;
    localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

    typedef enum logic { B_IDLE, B_BUSY } b_state_t;
    typedef enum logic { R_IDLE, R_BUSY } r_state_t;

    b_state_t b_state, b_state_nxt;
    r_state_t r_state, r_state_nxt;

    logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                          aw_full;
    logic [3:0]                    aw_idx_q;
    logic                          w_full;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]             w_strb_q;

    logic                          aw_hs;
    logic                          w_hs;
    logic                          ar_hs;
    logic                          commit;
    logic                          aw_mapped;
    logic [3:0]                    ar_idx;
    logic                          ar_mapped;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

    logic                          unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Handshake readiness is forced low for the whole time reset is asserted.
    assign S_AXI_BVALID  = (b_state == B_BUSY);
    assign S_AXI_RVALID  = (r_state == R_BUSY);
    assign S_AXI_AWREADY = !ARESET && !aw_full && !S_AXI_BVALID;
    assign S_AXI_WREADY  = !ARESET && !w_full  && !S_AXI_BVALID;
    assign S_AXI_ARREADY = !ARESET && !S_AXI_RVALID;

    assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs      = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
    assign commit    = aw_full && w_full;
    assign aw_mapped = (aw_idx_q[3:2] == 2'b00);
    assign ar_idx    = S_AXI_ARADDR[5:2];
    assign ar_mapped = (ar_idx[3:2] == 2'b00);
    assign rd_word   = ar_mapped ? regs[ar_idx[1:0]] : '0;

    // Address holding slot.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_full  <= 1'b0;
            aw_idx_q <= '0;
        end else if (commit) begin
            aw_full  <= 1'b0;
        end else if (aw_hs) begin
            aw_full  <= 1'b1;
            aw_idx_q <= S_AXI_AWADDR[5:2];
        end
    end

    // Data holding slot.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_full   <= 1'b0;
            w_data_q <= '0;
            w_strb_q <= '0;
        end else if (commit) begin
            w_full   <= 1'b0;
        end else if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
        end
    end

    // Register file: byte-lane merge on commit; unmapped slots drop the data.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (commit && aw_mapped) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb_q[b]) begin
                    regs[aw_idx_q[1:0]][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_slv_regs
            assign slv_regs[g*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs[g];
        end
    endgenerate

    // Write response channel.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            b_state <= B_IDLE;
        end else begin
            b_state <= b_state_nxt;
        end
    end

    always_comb begin
        b_state_nxt = b_state;
        case (b_state)
            B_IDLE: if (commit)       b_state_nxt = B_BUSY;
            B_BUSY: if (S_AXI_BREADY) b_state_nxt = B_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_BRESP <= RESP_OKAY;
        end else if (commit) begin
            S_AXI_BRESP <= aw_mapped ? RESP_OKAY : RESP_UNMAPPED;
        end
    end

    // Read response channel; a read coinciding with a commit sees the pre-write value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE: if (ar_hs)        r_state_nxt = R_BUSY;
            R_BUSY: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            S_AXI_RDATA <= '0;
            S_AXI_RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RDATA <= rd_word;
            S_AXI_RRESP <= ar_mapped ? RESP_OKAY : RESP_UNMAPPED;
        end
    end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave against a word/byte-mask register model.
module tb_axi_lite_reg_slave;

    logic         tb_ACLK;
    logic         tb_ARESET;
    logic [5:0]   S_AXI_AWADDR;
    logic [2:0]   S_AXI_AWPROT;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA;
    logic [3:0]   S_AXI_WSTRB;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [5:0]   S_AXI_ARADDR;
    logic [2:0]   S_AXI_ARPROT;
    logic         S_AXI_ARVALID;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY;
    logic [127:0] slv_regs;

    int total;
    int bad;

    logic [31:0] model_regs [4];

`ifdef AXIL_REG_SLVERR_EN
    localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

    axi_lite_reg_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(6)) dut (
        .ACLK          (tb_ACLK),
        .ARESET        (tb_ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .slv_regs      (slv_regs)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    function automatic logic [1:0] exp_resp(input logic [5:0] addr);
        return (addr[5:2] > 4'd3) ? EXP_UNMAPPED : 2'b00;
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] addr);
        return (addr[5:2] < 4'd4) ? model_regs[addr[3:2]] : 32'h0;
    endfunction

    function automatic void model_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{strb[b]}};
        if (addr[5:2] < 4'd4)
            model_regs[addr[3:2]] = (model_regs[addr[3:2]] & ~mask) | (data & mask);
    endfunction

    function automatic logic [127:0] model_flat();
        return {model_regs[3], model_regs[2], model_regs[1], model_regs[0]};
    endfunction

    // Drives AW and W with independent start delays; lat counts cycles from the later handshake to BVALID.
    task automatic do_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_d, input int w_d, output int lat, output logic [1:0] resp);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw;
        bit hs_w;
        int c = 0;
        S_AXI_AWADDR = addr;
        S_AXI_WDATA  = data;
        S_AXI_WSTRB  = strb;
        S_AXI_BREADY = 1'b1;
        while (!(aw_done && w_done) && c < 50) begin
            S_AXI_AWVALID = !aw_done && (c >= aw_d);
            S_AXI_WVALID  = !w_done && (c >= w_d);
            hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            hs_w  = S_AXI_WVALID && S_AXI_WREADY;
            @(posedge tb_ACLK); #1;
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done = 1;
            c++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        lat = 1;
        while (!S_AXI_BVALID && lat < 20) begin
            @(posedge tb_ACLK); #1;
            lat++;
        end
        resp = S_AXI_BRESP;
        if (S_AXI_BVALID) begin
            @(posedge tb_ACLK); #1;
        end
    endtask

    task automatic do_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp, output int lat);
        int c = 0;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        S_AXI_RREADY  = 1'b0;
        while (!S_AXI_ARREADY && c < 20) begin
            @(posedge tb_ACLK); #1;
            c++;
        end
        @(posedge tb_ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        lat = 1;
        while (!S_AXI_RVALID && lat < 20) begin
            @(posedge tb_ACLK); #1;
            lat++;
        end
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_reset();
        tb_ARESET = 1'b1;
        repeat (2) @(posedge tb_ACLK);
        #1;
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            bad++; $display("FAIL reset_ready: got %b expected 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        total++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
            bad++; $display("FAIL reset_valid: got %b expected 00", {S_AXI_BVALID, S_AXI_RVALID});
        end
        total++; if (slv_regs !== 128'h0) begin
            bad++; $display("FAIL reset_regs: got %h expected 0", slv_regs);
        end
        total++; if ({S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP} !== 36'h0) begin
            bad++; $display("FAIL reset_outputs: got %h expected 0", {S_AXI_RDATA, S_AXI_BRESP, S_AXI_RRESP});
        end
        tb_ARESET = 1'b0;
        #1;
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            bad++; $display("FAIL post_reset_ready: got %b expected 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    endtask

    task automatic test_write_read();
        logic [5:0]  addrs [4];
        logic [31:0] datas [4];
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        addrs = '{6'h00, 6'h04, 6'h08, 6'h0C};
        datas = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
        for (int i = 0; i < 4; i++) begin
            do_write(addrs[i], datas[i], 4'hF, 0, 0, lat, resp);
            model_write(addrs[i], datas[i], 4'hF);
            total++; if (lat != 2) begin
                bad++; $display("FAIL wr_latency[%0d]: got %0d expected 2", i, lat);
            end
            total++; if (resp !== 2'b00) begin
                bad++; $display("FAIL wr_bresp[%0d]: got %b expected 00", i, resp);
            end
            do_read(addrs[i], rd, resp, lat);
            total++; if (rd !== datas[i]) begin
                bad++; $display("FAIL rd_data[%0d]: got %h expected %h", i, rd, datas[i]);
            end
            total++; if (resp !== 2'b00 || lat != 1) begin
                bad++; $display("FAIL rd_resp_lat[%0d]: got %b/%0d expected 00/1", i, resp, lat);
            end
        end
        total++; if (slv_regs !== model_flat()) begin
            bad++; $display("FAIL wr_slv_regs: got %h expected %h", slv_regs, model_flat());
        end
    endtask

    task automatic test_skew();
        int lat;
        S_AXI_BREADY = 1'b1;
        S_AXI_WDATA  = 32'h12345678;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_WVALID = 1'b0;
        total++; if (S_AXI_WREADY !== 1'b0) begin
            bad++; $display("FAIL skew_wready: got %b expected 0", S_AXI_WREADY);
        end
        repeat (2) begin
            @(posedge tb_ACLK); #1;
            total++; if (S_AXI_BVALID !== 1'b0 || S_AXI_WREADY !== 1'b0) begin
                bad++; $display("FAIL skew_wait: got bvalid=%b wready=%b expected 0/0", S_AXI_BVALID, S_AXI_WREADY);
            end
        end
        S_AXI_AWADDR  = 6'h04;
        S_AXI_AWVALID = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        lat = 1;
        while (!S_AXI_BVALID && lat < 20) begin
            @(posedge tb_ACLK); #1;
            lat++;
        end
        total++; if (lat != 2) begin
            bad++; $display("FAIL skew_latency: got %0d expected 2", lat);
        end
        model_write(6'h04, 32'h12345678, 4'hF);
        repeat (3) begin
            @(posedge tb_ACLK); #1;
            total++; if (S_AXI_BVALID !== 1'b0) begin
                bad++; $display("FAIL skew_single_commit: got bvalid=%b expected 0", S_AXI_BVALID);
            end
        end
        total++; if (slv_regs[63:32] !== 32'h12345678) begin
            bad++; $display("FAIL skew_reg1: got %h expected 12345678", slv_regs[63:32]);
        end
    endtask

    task automatic test_strobe();
        int         lat;
        logic [1:0] resp;
        do_write(6'h08, 32'hDEAD0011, 4'hF, 0, 0, lat, resp);
        model_write(6'h08, 32'hDEAD0011, 4'hF);
        do_write(6'h08, 32'hFFFFFFFF, 4'b0101, 0, 0, lat, resp);
        model_write(6'h08, 32'hFFFFFFFF, 4'b0101);
        total++; if (slv_regs[95:64] !== 32'hDEFF00FF) begin
            bad++; $display("FAIL strobe_reg2: got %h expected DEFF00FF", slv_regs[95:64]);
        end
        total++; if (slv_regs !== model_flat()) begin
            bad++; $display("FAIL strobe_all: got %h expected %h", slv_regs, model_flat());
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] wd;
        logic [31:0] exp_rd;
        wd = $urandom;
        exp_rd = model_regs[3];
        S_AXI_BREADY  = 1'b0;
        S_AXI_RREADY  = 1'b0;
        S_AXI_AWADDR  = 6'h00;
        S_AXI_WDATA   = wd;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 6'h0C;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        @(posedge tb_ACLK); #1;
        model_write(6'h00, wd, 4'hF);
        // Competing requests during the hold must be ignored.
        S_AXI_AWADDR  = 6'h04;
        S_AXI_WDATA   = 32'hFFFFFFFF;
        S_AXI_ARADDR  = 6'h04;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11 || S_AXI_RDATA !== exp_rd || S_AXI_BRESP !== 2'b00) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b rdata=%h bresp=%b expected 11/%h/00",
                                i, {S_AXI_BVALID, S_AXI_RVALID}, S_AXI_RDATA, exp_rd, S_AXI_BRESP);
            end
            total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
                bad++; $display("FAIL bp_ready[%0d]: got %b expected 000", i, {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
            end
            @(posedge tb_ACLK); #1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY  = 1'b1;
        S_AXI_RREADY  = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_RREADY  = 1'b0;
        total++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin
            bad++; $display("FAIL bp_release: got %b expected 00", {S_AXI_BVALID, S_AXI_RVALID});
        end
        repeat (3) @(posedge tb_ACLK);
        #1;
        total++; if (S_AXI_BVALID !== 1'b0 || slv_regs !== model_flat()) begin
            bad++; $display("FAIL bp_no_stray_write: got bvalid=%b regs=%h expected 0/%h", S_AXI_BVALID, slv_regs, model_flat());
        end
    endtask

    task automatic test_coincide();
        logic [31:0] old_v;
        logic [31:0] new_v;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        old_v = model_regs[1];
        new_v = ~old_v ^ $urandom;
        S_AXI_BREADY  = 1'b1;
        S_AXI_RREADY  = 1'b0;
        S_AXI_AWADDR  = 6'h04;
        S_AXI_WDATA   = new_v;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARADDR  = 6'h04;
        S_AXI_ARVALID = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_ARVALID = 1'b0;
        total++; if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== old_v || S_AXI_BVALID !== 1'b1) begin
            bad++; $display("FAIL coincide_old: got rv=%b rdata=%h bv=%b expected 1/%h/1",
                            S_AXI_RVALID, S_AXI_RDATA, S_AXI_BVALID, old_v);
        end
        model_write(6'h04, new_v, 4'hF);
        S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_RREADY = 1'b0;
        do_read(6'h04, rd, resp, lat);
        total++; if (rd !== new_v) begin
            bad++; $display("FAIL coincide_new: got %h expected %h", rd, new_v);
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        do_write(6'h20, 32'hCAFEF00D, 4'hF, 0, 0, lat, resp);
        total++; if (resp !== EXP_UNMAPPED || lat != 2) begin
            bad++; $display("FAIL unmapped_bresp: got %b/%0d expected %b/2", resp, lat, EXP_UNMAPPED);
        end
        total++; if (slv_regs !== model_flat()) begin
            bad++; $display("FAIL unmapped_regs: got %h expected %h", slv_regs, model_flat());
        end
        do_read(6'h20, rd, resp, lat);
        total++; if (rd !== 32'h0 || resp !== EXP_UNMAPPED) begin
            bad++; $display("FAIL unmapped_read: got %h/%b expected 0/%b", rd, resp, EXP_UNMAPPED);
        end
    endtask

    task automatic test_random();
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            addr = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 2) != 0) begin
                data = $urandom;
                strb = 4'($urandom_range(0, 15));
                do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), lat, resp);
                model_write(addr, data, strb);
                total++; if (lat != 2 || resp !== exp_resp(addr)) begin
                    bad++; $display("FAIL rand_write[%0d] addr=%h: got lat=%0d resp=%b expected 2/%b", i, addr, lat, resp, exp_resp(addr));
                end
            end else begin
                do_read(addr, rd, resp, lat);
                total++; if (rd !== model_read(addr) || resp !== exp_resp(addr)) begin
                    bad++; $display("FAIL rand_read[%0d] addr=%h: got %h/%b expected %h/%b", i, addr, rd, resp, model_read(addr), exp_resp(addr));
                end
            end
        end
        total++; if (slv_regs !== model_flat()) begin
            bad++; $display("FAIL rand_final_regs: got %h expected %h", slv_regs, model_flat());
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic [1:0]  resp;
        int          lat;
        S_AXI_AWADDR  = 6'h04;
        S_AXI_AWVALID = 1'b1;
        @(posedge tb_ACLK); #1;
        S_AXI_AWVALID = 1'b0;
        total++; if (S_AXI_AWREADY !== 1'b0) begin
            bad++; $display("FAIL rstmid_aw_captured: got awready=%b expected 0", S_AXI_AWREADY);
        end
        tb_ARESET = 1'b1;
        #1;
        total++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            bad++; $display("FAIL rstmid_ready: got %b expected 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        @(posedge tb_ACLK); #1;
        tb_ARESET = 1'b0;
        for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge tb_ACLK); #1;
            total++; if (S_AXI_BVALID !== 1'b0) begin
                bad++; $display("FAIL rstmid_no_bvalid[%0d]: got %b expected 0", i, S_AXI_BVALID);
            end
        end
        total++; if (slv_regs !== 128'h0) begin
            bad++; $display("FAIL rstmid_regs: got %h expected 0", slv_regs);
        end
        do_write(6'h04, 32'h600DF00D, 4'hF, 0, 0, lat, resp);
        model_write(6'h04, 32'h600DF00D, 4'hF);
        do_read(6'h04, rd, resp, lat);
        total++; if (rd !== 32'h600DF00D || slv_regs !== model_flat()) begin
            bad++; $display("FAIL rstmid_next_write: got %h regs=%h expected 600DF00D/%h", rd, slv_regs, model_flat());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        tb_ARESET     = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = '0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = '0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = '0;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        test_reset();
        test_write_read();
        test_skew();
        test_strobe();
        test_backpressure();
        test_coincide();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
